// File: rtl/ram_perf_tester_if.sv
// Command / write / read channel between the perf tester and the RAM controller.
interface ram_perf_tester_if;
  logic [1:0]  cmd;
  logic [2:0]  cmd_block;
  logic        write_ready;
  logic        write_trigger;
  logic [15:0] write_data;
  logic        write_done;
  logic        read_ready;
  logic        read_trigger;
  logic [15:0] read_data;
  logic        read_done;

  // Tester side: issues commands, pushes write data, pulls read data.
  modport master (
    output cmd, cmd_block, write_trigger, write_data, read_trigger,
    input  write_ready, write_done, read_ready, read_data, read_done
  );

  // Controller side.
  modport slave (
    input  cmd, cmd_block, write_trigger, write_data, read_trigger,
    output write_ready, write_done, read_ready, read_data, read_done
  );
endinterface

// File: rtl/ram_perf_tester.sv
// Block write / read-back traffic generator with data check, error stats,
// per-phase cycle counters and a per-phase watchdog.
module ram_perf_tester #(
  parameter int unsigned BlockSize     = 2304*1296,
  parameter logic [1:0]  CmdNone       = 2'd0,
  parameter logic [1:0]  CmdRead       = 2'd1,
  parameter logic [1:0]  CmdWrite      = 2'd2,
  parameter logic [15:0] Seed          = 16'hA5C3,
  parameter int unsigned TimeoutCycles = 2**24
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        start,
  input  logic [2:0]  block,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [21:0] first_err_idx,
  output logic        timeout,
  output logic [31:0] write_cycles,
  output logic [31:0] read_cycles,
  ram_perf_tester_if.master ctrl
);
  // idx must be able to hold BlockSize itself
  localparam int IdxW = $clog2(BlockSize + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BlockSize - 1);
  localparam logic [31:0]     TmoLim  = 32'(TimeoutCycles);

  typedef enum logic [2:0] {
    S_IDLE, S_WCMD, S_WRITE, S_WWAIT, S_RCMD, S_READ, S_RWAIT, S_FIN
  } state_t;

  state_t          state_q, state_d;
  logic [IdxW-1:0] idx_q;
  logic [31:0]     cycle_q;
  logic [2:0]      block_q;
  logic            cmp_vld_q, cmp_bad_q;
  logic [IdxW-1:0] cmp_idx_q;
  logic [15:0]     err_q;
  logic [21:0]     first_q;
  logic            tmo_q, early_q, res_q;
  logic [31:0]     wcyc_q, rcyc_q;

  logic        wr_acc, rd_acc, counting, tmo_hit, early_ev, cmp_err;
  logic [15:0] pat;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  assign pat      = 16'(idx_q) ^ Seed;
  assign wr_acc   = ctrl.write_trigger && ctrl.write_ready;
  assign rd_acc   = ctrl.read_trigger && ctrl.read_ready;
  assign counting = (state_q == S_WRITE) || (state_q == S_WWAIT) ||
                    (state_q == S_READ)  || (state_q == S_RWAIT);
  assign tmo_hit  = counting && (cycle_q == TmoLim);
  // A done strobe while words are still outstanding ends the test as a failure
  assign early_ev = !tmo_hit && (((state_q == S_WRITE) && ctrl.write_done) ||
                                 ((state_q == S_READ)  && ctrl.read_done));
  assign cmp_err  = cmp_vld_q && cmp_bad_q;
  assign err_inc  = {1'b0, cmp_err} + {1'b0, early_ev};
  assign err_sum  = {1'b0, err_q} + 17'(err_inc);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; the transfer states exit on the last accepted word so
  // the trigger is already low when idx reaches BlockSize.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_WCMD;
      S_WCMD:  state_d = S_WRITE;
      S_WRITE: if (tmo_hit || ctrl.write_done)       state_d = S_FIN;
               else if (wr_acc && idx_q == LastIdx)  state_d = S_WWAIT;
      S_WWAIT: if (tmo_hit)                          state_d = S_FIN;
               else if (ctrl.write_done)             state_d = S_RCMD;
      S_RCMD:  state_d = S_READ;
      S_READ:  if (tmo_hit || ctrl.read_done)        state_d = S_FIN;
               else if (rd_acc && idx_q == LastIdx)  state_d = S_RWAIT;
      S_RWAIT: if (tmo_hit || ctrl.read_done)        state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Controller-facing and status outputs decoded from state
  always_comb begin
    ctrl.cmd           = CmdNone;
    ctrl.cmd_block     = 3'd0;
    ctrl.write_trigger = 1'b0;
    ctrl.read_trigger  = 1'b0;
    busy               = 1'b0;
    done               = 1'b0;
    unique case (state_q)
      S_WCMD:  begin ctrl.cmd = CmdWrite; ctrl.cmd_block = block_q; end
      S_RCMD:  begin ctrl.cmd = CmdRead;  ctrl.cmd_block = block_q; end
      S_WRITE: ctrl.write_trigger = 1'b1;
      S_READ:  ctrl.read_trigger  = 1'b1;
      default: ;
    endcase
    busy = (state_q != S_IDLE) && (state_q != S_FIN);
    done = (state_q == S_FIN);
  end

  // Data path: index, phase counter, registered compare, result capture
  always_ff @(posedge clk) begin
    if (!rst_) begin
      idx_q     <= '0;
      cycle_q   <= '0;
      block_q   <= '0;
      cmp_vld_q <= 1'b0;
      cmp_bad_q <= 1'b0;
      cmp_idx_q <= '0;
      err_q     <= '0;
      first_q   <= '0;
      tmo_q     <= 1'b0;
      early_q   <= 1'b0;
      res_q     <= 1'b0;
      wcyc_q    <= '0;
      rcyc_q    <= '0;
    end else begin
      if (state_q == S_IDLE && start) begin
        block_q <= block;
        err_q   <= '0;
        first_q <= '0;
        tmo_q   <= 1'b0;
        early_q <= 1'b0;
        res_q   <= 1'b0;
        wcyc_q  <= '0;
        rcyc_q  <= '0;
      end else begin
        err_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        if (cmp_err && err_q == 16'd0) first_q <= 22'(cmp_idx_q);
        if (early_ev) early_q <= 1'b1;
        if (tmo_hit)  tmo_q   <= 1'b1;
        if (state_q == S_FIN) res_q <= 1'b1;
      end

      if (state_q == S_WCMD || state_q == S_RCMD) begin
        cycle_q <= '0;
        idx_q   <= '0;
      end else begin
        if (counting) cycle_q <= cycle_q + 32'd1;
        if (wr_acc || (rd_acc && !early_ev)) idx_q <= idx_q + 1'b1;
      end

      // the compare lands one cycle after the accept; a word accepted
      // together with an early done is not checked
      cmp_vld_q <= rd_acc && !early_ev && !tmo_hit;
      cmp_bad_q <= ctrl.read_data != pat;
      cmp_idx_q <= idx_q;

      if (state_q == S_WWAIT && ctrl.write_done && !tmo_hit) wcyc_q <= cycle_q + 32'd1;
      if (state_q == S_RWAIT && ctrl.read_done  && !tmo_hit) rcyc_q <= cycle_q + 32'd1;
    end
  end

  assign ctrl.write_data = ctrl.write_trigger ? pat : 16'd0;
  assign err_count       = err_q;
  assign first_err_idx   = first_q;
  assign timeout         = tmo_q;
  assign write_cycles    = wcyc_q;
  assign read_cycles     = rcyc_q;
  assign pass            = (done || res_q) && (err_q == 16'd0) && !tmo_q && !early_q;
endmodule

// File: tb/tb_ram_perf_tester.sv
// Bench: small controller model, write-data scoreboard and per-run result queue.
module tb_ram_perf_tester;
  localparam logic [15:0] SEED = 16'hA5C3;
  localparam logic [1:0]  CNONE = 2'd0, CREAD = 2'd1, CWRITE = 2'd2;

  logic        clk = 1'b0;
  logic        rst_;
  logic        start;
  logic [2:0]  block;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [21:0] first_err_idx;
  logic [31:0] write_cycles, read_cycles;

  ram_perf_tester_if bus ();

  ram_perf_tester #(.BlockSize(16), .TimeoutCycles(64)) dut (
    .clk(clk), .rst_(rst_), .start(start), .block(block),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_idx(first_err_idx), .timeout(timeout),
    .write_cycles(write_cycles), .read_cycles(read_cycles), .ctrl(bus)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- controller model ----------------
  bit          m_tog = 1'b0, m_nowd = 1'b0;
  int          m_early = 0;
  logic [15:0] m_corrupt = '0;
  logic        tog_q = 1'b0, wdone_q = 1'b0, rdone_q = 1'b0;
  int          wcnt = 0, rcnt = 0;
  logic [15:0] mem [16];

  assign bus.write_ready = m_tog ? tog_q : 1'b1;
  assign bus.read_ready  = 1'b1;
  assign bus.write_done  = wdone_q;
  assign bus.read_done   = rdone_q;
  assign bus.read_data   = mem[rcnt[3:0]] ^ (m_corrupt[rcnt[3:0]] ? 16'h0100 : 16'h0000);

  always @(posedge clk) begin
    tog_q   <= ~tog_q;
    wdone_q <= 1'b0;
    rdone_q <= 1'b0;
    if (bus.cmd == CWRITE) begin wcnt <= 0; tog_q <= 1'b0; end
    if (bus.cmd == CREAD)  rcnt <= 0;
    if (bus.write_trigger && bus.write_ready) begin
      mem[wcnt[3:0]] <= bus.write_data;
      wcnt <= wcnt + 1;
      if (wcnt == 15 && !m_nowd) wdone_q <= 1'b1;
    end
    if (bus.read_trigger && bus.read_ready) begin
      rcnt <= rcnt + 1;
      if (m_early != 0 ? (rcnt == m_early - 1) : (rcnt == 15)) rdone_q <= 1'b1;
    end
  end

  // ---------------- write scoreboard / command monitor ----------------
  logic [15:0] wq[$];
  int          ncmdw = 0;
  logic [2:0]  cap_blk = '0;

  always @(negedge clk) begin
    if (rst_ && bus.write_trigger && bus.write_ready) begin
      if (wq.size() == 0) chk("wr_extra", 32'd1, 32'd0);
      else                chk("wr_data", 32'(bus.write_data), 32'(wq.pop_front()));
    end
    if (bus.cmd == CWRITE) begin ncmdw++; cap_blk = bus.cmd_block; end
  end

  typedef struct {
    logic        pas;
    logic [15:0] err;
    logic [21:0] first;
    logic        tmo;
    logic [31:0] wc, rc;
    logic [2:0]  blk;
  } exp_t;
  exp_t res_q[$];

  task automatic chk_rst(input string tag);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_pass"},  32'(pass), 0);
    chk({tag, "_err"},   32'(err_count), 0);
    chk({tag, "_first"}, 32'(first_err_idx), 0);
    chk({tag, "_tmo"},   32'(timeout), 0);
    chk({tag, "_wc"},    write_cycles, 0);
    chk({tag, "_rc"},    read_cycles, 0);
    chk({tag, "_cmd"},   32'(bus.cmd), 32'(CNONE));
    chk({tag, "_cblk"},  32'(bus.cmd_block), 0);
    chk({tag, "_trig"},  32'({bus.write_trigger, bus.read_trigger}), 0);
    chk({tag, "_wdata"}, 32'(bus.write_data), 0);
  endtask

  task automatic run_test(input string tag, input logic [2:0] blk, input bit tog,
                          input bit nowd, input int early, input logic [15:0] corrupt,
                          input bit extra, input exp_t e);
    bit   seen;
    int   ntrig;
    exp_t x;
    m_tog = tog; m_nowd = nowd; m_early = early; m_corrupt = corrupt;
    for (int i = 0; i < 16; i++) wq.push_back(16'(i) ^ SEED);
    res_q.push_back(e);
    ncmdw = 0;
    start = 1'b1; block = blk;
    @(negedge clk);
    start = 1'b0; block = 3'd0;
    seen = 1'b0;
    for (int c = 0; c < 500 && !seen; c++) begin
      if (extra && c == 3) begin start = 1'b1; block = 3'd5; end
      else                 begin start = 1'b0; block = 3'd0; end
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    start = 1'b0; block = 3'd0;
    chk({tag, "_done_seen"}, 32'(seen), 1);
    x = res_q.pop_front();
    if (seen) begin
      chk({tag, "_pass"},  32'(pass), 32'(x.pas));
      chk({tag, "_err"},   32'(err_count), 32'(x.err));
      chk({tag, "_first"}, 32'(first_err_idx), 32'(x.first));
      chk({tag, "_tmo"},   32'(timeout), 32'(x.tmo));
      chk({tag, "_wc"},    write_cycles, x.wc);
      chk({tag, "_rc"},    read_cycles, x.rc);
      chk({tag, "_blk"},   32'(cap_blk), 32'(x.blk));
      chk({tag, "_ncmdw"}, 32'(ncmdw), 1);
      chk({tag, "_cmd"},   32'(bus.cmd), 32'(CNONE));
      chk({tag, "_busy"},  32'(busy), 0);
      ntrig = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (bus.read_trigger || bus.write_trigger || done) ntrig++;
      end
      chk({tag, "_quiet_after"}, 32'(ntrig), 0);
      chk({tag, "_pass_hold"}, 32'(pass), 32'(x.pas));
      chk({tag, "_err_hold"},  32'(err_count), 32'(x.err));
      chk({tag, "_wq_empty"},  32'(wq.size()), 0);
    end
    wq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    rst_ = 1'b0; start = 1'b0; block = 3'd0;
    repeat (3) @(negedge clk);
    chk_rst("rst0");
    rst_ = 1'b1;
    @(negedge clk);

    run_test("ideal", 3'd2, 0, 0, 0, 16'h0000, 0,
             exp_t'{1'b1, 16'd0, 22'd0, 1'b0, 32'd17, 32'd17, 3'd2});
    run_test("corrupt", 3'd1, 0, 0, 0, 16'h0220, 0,
             exp_t'{1'b0, 16'd2, 22'd5, 1'b0, 32'd17, 32'd17, 3'd1});
    run_test("toggle", 3'd4, 1, 0, 0, 16'h0000, 0,
             exp_t'{1'b1, 16'd0, 22'd0, 1'b0, 32'd33, 32'd17, 3'd4});
    run_test("early_rd", 3'd6, 0, 0, 10, 16'h0000, 0,
             exp_t'{1'b0, 16'd1, 22'd0, 1'b0, 32'd17, 32'd0, 3'd6});
    run_test("wdog", 3'd7, 0, 1, 0, 16'h0000, 0,
             exp_t'{1'b0, 16'd0, 22'd0, 1'b1, 32'd0, 32'd0, 3'd7});

    // abort a run partway through the read phase
    m_tog = 1'b0; m_nowd = 1'b0; m_early = 0; m_corrupt = '0;
    for (int i = 0; i < 16; i++) wq.push_back(16'(i) ^ SEED);
    start = 1'b1; block = 3'd2;
    @(negedge clk);
    start = 1'b0; block = 3'd0;
    n = 0;
    for (int c = 0; c < 200 && n < 4; c++) begin
      @(negedge clk);
      if (bus.read_trigger) n++;
    end
    chk("abort_reached_read", 32'(n), 4);
    rst_ = 1'b0;
    @(negedge clk);
    chk_rst("rst_mid");
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    wq.delete();

    run_test("after_rst", 3'd3, 0, 0, 0, 16'h0000, 1,
             exp_t'{1'b1, 16'd0, 22'd0, 1'b0, 32'd17, 32'd17, 3'd3});

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/ram_perf_tester.md
# ram_perf_tester

Self-checking traffic generator that sits directly upstream of the RAM controller in the RAM performance-test design. On a start pulse it commands a full-block write of a deterministic pattern, then a full-block read-back of the same block. It compares every returned word and reports pass/fail, error count, first failing index and per-phase cycle counts. All controller-facing outputs connect port-for-port to the controller's command/write/read interface.

## Interface
- BlockSize, 2304*1296: words per block; must match the controller.
- CmdNone, 2'd0: controller idle command.
- CmdRead, 2'd1: controller read command.
- CmdWrite, 2'd2: controller write command.
- Seed, 16'hA5C3: pattern XOR constant.
- TimeoutCycles, 2**24: watchdog limit per phase.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; sampled only in Idle.
- block  in  3  block to test; latched on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at test end.
- pass  out  1  valid from done until next start.
- err_count  out  16  mismatching words, saturating at 16'hFFFF.
- first_err_idx  out  22  word index of the first mismatch; 0 if none.
- timeout  out  1  set if either phase hit TimeoutCycles.
- write_cycles  out  32  cycles from write-command issue to write_done.
- read_cycles  out  32  cycles from read-command issue to read_done.
- cmd  out  2  to controller cmd.
- cmd_block  out  3  to controller cmd_block.
- write_ready  in  1  from controller.
- write_trigger  out  1  to controller.
- write_data  out  16  to controller.
- write_done  in  1  from controller.
- read_ready  in  1  from controller.
- read_trigger  out  1  to controller.
- read_data  in  16  from controller.
- read_done  in  1  from controller.

## Operation
- Pattern: word i = i[15:0] ^ Seed, where the index counter idx is clog2(BlockSize) bits wide (22 bits at default) and wraps modulo 2^16 in the data only.
- States:
  - Idle: on start, latch block, clear all results, set busy, go to WriteCmd.
  - WriteCmd: drive cmd=CmdWrite and cmd_block=block for exactly one cycle, clear the cycle counter, go to Write.
  - Write: write_trigger=1 while idx<BlockSize. A word transfers on each cycle with write_ready&&write_trigger, and then idx and write_data advance the next cycle. At idx==BlockSize, drop the trigger and go to WriteWait.
  - WriteWait: on write_done, latch write_cycles, reset idx, go to ReadCmd.
  - ReadCmd: drive cmd=CmdRead for one cycle, go to Read.
  - Read: read_trigger=1 while idx<BlockSize. On read_ready&&read_trigger, compare read_data with pattern(idx) and advance idx. At idx==BlockSize go to ReadWait.
  - ReadWait: on read_done, latch read_cycles, go to Finish.
  - Finish: pulse done, clear busy, return to Idle.
- cmd=CmdNone in every state except WriteCmd and ReadCmd.
- Mismatch handling: err_count increments and saturates. first_err_idx is captured only on the first mismatch.
- Early done: write_done in Write, or read_done in Read, before the count completes is treated as a failure. Jump to Finish, force pass=0, and bump err_count by 1.
- Watchdog: the phase cycle counter reaching TimeoutCycles in any non-Idle state sets timeout, forces pass=0, and jumps to Finish.
- Pass rule: pass = (err_count==0) && !timeout && no early done.
- Reset: synchronous. Aborts any phase immediately and returns to Idle.
- Reset values: all outputs 0; cmd=CmdNone; cmd_block=0.

## Timing
- Start to cmd=CmdWrite: 1 cycle.
- Cycle counters: increment every cycle after the command cycle up to and including the done cycle. A controller that returns write_done the cycle after the last transfer on an always-ready path gives write_cycles = BlockSize+1.
- Write data: write_data is valid in the same cycle as write_trigger; it changes only after an accepted transfer.
- Read data: read_data is sampled in the accept cycle. The compare result is registered, so err_count lags the accept by 1 cycle. done is never asserted before that final update.
- Results: hold stable from done until the next accepted start.
- Ignored events: start while busy is ignored. A done strobe seen outside its wait or transfer state is ignored.

## Test plan
- Ideal controller model (ready always high, done 1 cycle after the last word), BlockSize=16: pass=1, err_count=0, write_cycles=17, read_cycles=17, write_data sequence Seed^0..Seed^15.
- Model corrupts word 5 and word 9 on read: err_count=2, first_err_idx=5, pass=0.
- write_ready toggling 1/0 every cycle: exactly 16 write transfers with no duplicated or skipped data, write_cycles=33, pass=1.
- read_done asserted after 10 words: done pulse, pass=0, err_count=1, no further read_trigger.
- Model never asserts write_done, TimeoutCycles=64: timeout=1, pass=0, done pulses, cmd returns to CmdNone.
- rst_ low mid-Read, then start again with block=3: all outputs at reset values, then a clean run with cmd_block=3 and pass=1; a start pulse sent while busy is ignored.
